// File: rtl/register_file_if.sv
// Register file access bundle: write port, two read ports,
// scoreboard reserve/flush controls and busy status.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  reserve;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic                  flush;
    logic                  busy_a;
    logic                  busy_b;
    logic                  any_busy;

    modport master (
        output enable, write_addr, write_data,
        output read_addr_a, read_addr_b,
        output reserve, reserve_addr, flush,
        input  read_data_a, read_data_b,
        input  busy_a, busy_b, any_busy
    );

    modport slave (
        input  enable, write_addr, write_data,
        input  read_addr_a, read_addr_b,
        input  reserve, reserve_addr, flush,
        output read_data_a, read_data_b,
        output busy_a, busy_b, any_busy
    );
endinterface

// File: rtl/register_file.sv
// Register file with two combinational read ports, one write
// port and per-register busy bits for in-flight producers.
// Ports: clock, clear (async active-high), bus (slave side):
//   enable/write_addr/write_data  - write port
//   read_addr_a/b, read_data_a/b  - read ports
//   reserve/reserve_addr/flush    - busy-bit control
//   busy_a/b, any_busy            - busy status
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter bit                    ZERO_REG0  = 1'b1,
    parameter bit                    BYPASS     = 1'b1
) (
    input logic            clock,
    input logic            clear,
    register_file_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic                  wr_ok;
    logic                  rsv_ok;
    logic                  hit_a;
    logic                  hit_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Register 0 is hardwired when ZERO_REG0 is set, so both
    // writes and reservations to it are simply dropped.
    assign wr_ok = bus.enable &&
        !(ZERO_REG0 && bus.write_addr == '0);
    assign rsv_ok = bus.reserve &&
        !(ZERO_REG0 && bus.reserve_addr == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.write_addr] = bus.write_data;
        end
    end

    // Later assignments take priority: a write retires the
    // producer, a same-cycle reserve re-arms it, flush beats all.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[bus.write_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[bus.reserve_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ZERO_REG0 && i == 0) begin
                    regs_q[i] <= '0;
                end else begin
                    regs_q[i] <= INIT;
                end
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign hit_a = BYPASS && wr_ok &&
        (bus.read_addr_a == bus.write_addr);
    assign hit_b = BYPASS && wr_ok &&
        (bus.read_addr_b == bus.write_addr);

    always_comb begin
        rd_a = regs_q[bus.read_addr_a];
        if (hit_a) begin
            rd_a = bus.write_data;
        end
        if (ZERO_REG0 && bus.read_addr_a == '0) begin
            rd_a = '0;
        end
    end

    always_comb begin
        rd_b = regs_q[bus.read_addr_b];
        if (hit_b) begin
            rd_b = bus.write_data;
        end
        if (ZERO_REG0 && bus.read_addr_b == '0) begin
            rd_b = '0;
        end
    end

    assign bus.read_data_a = rd_a;
    assign bus.read_data_b = rd_b;
    assign bus.busy_a      = busy_q[bus.read_addr_a];
    assign bus.busy_b      = busy_q[bus.read_addr_b];
    assign bus.any_busy    = |busy_q;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: default config table
// plus a BYPASS=0 / INIT / async-clear sequence.
module tb_register_file;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic clear = 1'b1;

    always #5 clock = ~clock;

    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    register_file #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut0 (
        .clock(clock), .clear(clear), .bus(bus0)
    );

    register_file #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .INIT(32'hFFFF_0000), .ZERO_REG0(1'b0), .BYPASS(1'b0)
    ) dut1 (
        .clock(clock), .clear(clear), .bus(bus1)
    );

    typedef struct {
        logic          en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          rsv;
        logic [AW-1:0] rsa;
        logic          fl;
        logic [DW-1:0] xa;
        logic [DW-1:0] xb;
        logic          xba;
        logic          xbb;
        logic          xany;
    } vec_t;

    typedef struct {
        string         name;
        logic [DW-1:0] xa;
        logic [DW-1:0] xb;
        logic          xba;
        logic          xbb;
        logic          xany;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic en, input logic [AW-1:0] wa,
        input logic [DW-1:0] wd,
        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
        input logic rsv, input logic [AW-1:0] rsa,
        input logic fl,
        input logic [DW-1:0] xa, input logic [DW-1:0] xb,
        input logic xba, input logic xbb, input logic xany);
        vec_t v;
        v.en = en; v.wa = wa; v.wd = wd;
        v.ra = ra; v.rb = rb;
        v.rsv = rsv; v.rsa = rsa; v.fl = fl;
        v.xa = xa; v.xb = xb;
        v.xba = xba; v.xbb = xbb; v.xany = xany;
        return v;
    endfunction

    task automatic drive(input int which, input vec_t v,
                         input string name);
        exp_t e;
        if (which == 0) begin
            bus0.enable       = v.en;
            bus0.write_addr   = v.wa;
            bus0.write_data   = v.wd;
            bus0.read_addr_a  = v.ra;
            bus0.read_addr_b  = v.rb;
            bus0.reserve      = v.rsv;
            bus0.reserve_addr = v.rsa;
            bus0.flush        = v.fl;
        end else begin
            bus1.enable       = v.en;
            bus1.write_addr   = v.wa;
            bus1.write_data   = v.wd;
            bus1.read_addr_a  = v.ra;
            bus1.read_addr_b  = v.rb;
            bus1.reserve      = v.rsv;
            bus1.reserve_addr = v.rsa;
            bus1.flush        = v.fl;
        end
        e.name = name;
        e.xa = v.xa; e.xb = v.xb;
        e.xba = v.xba; e.xbb = v.xbb; e.xany = v.xany;
        sb.push_back(e);
    endtask

    task automatic sample(input int which);
        exp_t          e;
        logic [DW-1:0] ga, gb;
        logic          gba, gbb, gany;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: empty queue, want 1 entry");
            return;
        end
        e = sb.pop_front();
        if (which == 0) begin
            ga = bus0.read_data_a; gb = bus0.read_data_b;
            gba = bus0.busy_a; gbb = bus0.busy_b;
            gany = bus0.any_busy;
        end else begin
            ga = bus1.read_data_a; gb = bus1.read_data_b;
            gba = bus1.busy_a; gbb = bus1.busy_b;
            gany = bus1.any_busy;
        end
        if (ga !== e.xa || gb !== e.xb || gba !== e.xba ||
            gbb !== e.xbb || gany !== e.xany) begin
            n_bad++;
            $display({"FAIL %s: got a=%h b=%h ba=%b bb=%b ",
                      "any=%b, want a=%h b=%h ba=%b bb=%b any=%b"},
                     e.name, ga, gb, gba, gbb, gany,
                     e.xa, e.xb, e.xba, e.xbb, e.xany);
        end
    endtask

    task automatic step(input int which, input vec_t v,
                        input string name);
        @(posedge clock);
        #1;
        drive(which, v, name);
        @(negedge clock);
        sample(which);
    endtask

    task automatic idle_all();
        bus0.enable = 1'b0; bus0.write_addr = '0;
        bus0.write_data = '0; bus0.read_addr_a = '0;
        bus0.read_addr_b = '0; bus0.reserve = 1'b0;
        bus0.reserve_addr = '0; bus0.flush = 1'b0;
        bus1.enable = 1'b0; bus1.write_addr = '0;
        bus1.write_data = '0; bus1.read_addr_a = '0;
        bus1.read_addr_b = '0; bus1.reserve = 1'b0;
        bus1.reserve_addr = '0; bus1.flush = 1'b0;
    endtask

    initial begin
        // Default config: INIT=0, ZERO_REG0=1, BYPASS=1.
        //                 en wa  wd            ra  rb  rs rsa fl
        //                 xa            xb            ba bb any
        tbl.push_back(mk(0, 0, 0,            5,  0,  0, 0,  0,
                         0,            0,            0, 0, 0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 5,  5,  0, 0,  0,
                         32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            5,  1,  0, 0,  0,
                         32'hDEADBEEF, 0,            0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h12345678, 0,  0,  1, 0,  0,
                         0,            0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0,  0,  0, 0,  0,
                         0,            0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            3,  3,  1, 3,  0,
                         0,            0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1,  3,  0, 0,  0,
                         0,            0,            0, 1, 1));
        tbl.push_back(mk(1, 3, 32'hA5,       3,  3,  0, 0,  0,
                         32'hA5,       32'hA5,       1, 1, 1));
        tbl.push_back(mk(0, 0, 0,            5,  3,  0, 0,  0,
                         32'hDEADBEEF, 32'hA5,       0, 0, 0));
        tbl.push_back(mk(1, 7, 32'h55,       7,  7,  1, 7,  0,
                         32'h55,       32'h55,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            7,  7,  0, 0,  0,
                         32'h55,       32'h55,       1, 1, 1));
        tbl.push_back(mk(0, 0, 0,            2,  7,  1, 2,  1,
                         0,            32'h55,       0, 1, 1));
        tbl.push_back(mk(0, 0, 0,            2,  7,  0, 0,  0,
                         0,            32'h55,       0, 0, 0));
        tbl.push_back(mk(1, 4, 32'h77,       4,  4,  0, 0,  0,
                         32'h77,       32'h77,       0, 0, 0));
        tbl.push_back(mk(1, 6, 32'h11,       6,  4,  1, 6,  1,
                         32'h11,       32'h77,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            6,  4,  0, 0,  0,
                         32'h11,       32'h77,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1,  2,  1, 1,  0,
                         0,            0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1,  2,  1, 2,  0,
                         0,            0,            1, 0, 1));
        tbl.push_back(mk(1, 1, 32'hCAFE,     1,  2,  0, 0,  0,
                         32'hCAFE,     0,            1, 1, 1));
        tbl.push_back(mk(0, 0, 0,            1,  2,  0, 0,  0,
                         32'hCAFE,     0,            0, 1, 1));
        tbl.push_back(mk(1, 15, 32'hFFFFFFFF, 15, 2, 0, 0,  0,
                         32'hFFFFFFFF, 0,            0, 1, 1));
        tbl.push_back(mk(0, 0, 0,            15, 15, 0, 0,  0,
                         32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1));

        idle_all();
        clear = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;

        foreach (tbl[i]) begin
            step(0, tbl[i], $sformatf("d0_v%0d", i));
        end
        @(posedge clock);
        #1;
        idle_all();

        // BYPASS=0, ZERO_REG0=0, INIT=FFFF0000 instance.
        step(1, mk(0, 0, 0, 0, 9, 0, 0, 0,
                   32'hFFFF0000, 32'hFFFF0000, 0, 0, 0), "d1_rst");
        step(1, mk(1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0,
                   32'hFFFF0000, 32'hFFFF0000, 0, 0, 0), "d1_nobyp");
        step(1, mk(0, 0, 0, 5, 0, 0, 0, 0,
                   32'hDEADBEEF, 32'hFFFF0000, 0, 0, 0), "d1_wr5");
        step(1, mk(1, 0, 32'h12345678, 0, 0, 1, 0, 0,
                   32'hFFFF0000, 32'hFFFF0000, 0, 0, 0), "d1_w0");
        step(1, mk(0, 0, 0, 0, 0, 0, 0, 0,
                   32'h12345678, 32'h12345678, 1, 1, 1), "d1_r0");
        step(1, mk(1, 9, 32'h1, 9, 0, 0, 0, 0,
                   32'hFFFF0000, 32'h12345678, 0, 1, 1), "d1_w9");
        step(1, mk(0, 0, 0, 9, 0, 0, 0, 0,
                   32'h1, 32'h12345678, 0, 1, 1), "d1_r9");

        // Clear between edges with a write pending.
        #2;
        drive(1, mk(1, 9, 32'h2, 9, 0, 0, 0, 0,
                    32'hFFFF0000, 32'hFFFF0000, 0, 0, 0),
              "d1_clr_async");
        clear = 1'b1;
        #1;
        sample(1);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        drive(1, mk(0, 0, 0, 9, 0, 0, 0, 0,
                    32'hFFFF0000, 32'hFFFF0000, 0, 0, 0),
              "d1_clr_rel");
        #1;
        sample(1);
        step(1, mk(0, 0, 0, 9, 5, 0, 0, 0,
                   32'hFFFF0000, 32'hFFFF0000, 0, 0, 0),
             "d1_after");
        step(0, mk(0, 0, 0, 5, 7, 0, 0, 0,
                   0, 0, 0, 0, 0), "d0_after_clr");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of each register and data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning address width; register count NUM_REGS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter INIT, default 0 (DATA_WIDTH bits), meaning value loaded into every register at reset.
REQ-004 SHALL have parameter ZERO_REG0, default 1, meaning when 1 register 0 always reads 0, ignores writes and is never busy.
REQ-005 SHALL have parameter BYPASS, default 1, meaning when 1 a same-cycle write is forwarded to matching read ports.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port enable  input  1  write enable.
REQ-009 SHALL have port write_addr  input  ADDR_WIDTH  write target.
REQ-010 SHALL have port write_data  input  DATA_WIDTH  write value.
REQ-011 SHALL have ports read_addr_a, read_addr_b  input  ADDR_WIDTH  read port A/B select.
REQ-012 SHALL have ports read_data_a, read_data_b  output  DATA_WIDTH  read port A/B data.
REQ-013 SHALL have port reserve  input  1  mark reserve_addr busy (in-flight producer).
REQ-014 SHALL have port reserve_addr  input  ADDR_WIDTH  register to mark busy.
REQ-015 SHALL have port flush  input  1  synchronous clear of all busy bits.
REQ-016 SHALL have ports busy_a, busy_b  output  1  busy bit of read_addr_a / read_addr_b.
REQ-017 SHALL have port any_busy  output  1  OR of all busy bits.

Function
REQ-018 SHALL write write_data into register write_addr on the rising clock edge when enable=1 (one-cycle write latency).
REQ-019 SHALL drive read_data_a/b combinationally from the register array (zero-cycle read latency).
REQ-020 SHALL, when BYPASS=1 and enable=1 and read address equals write_addr, drive write_data on that read port in the same cycle.
REQ-021 SHALL, when BYPASS=0, return the pre-write register value in the write cycle and the new value from the next cycle.
REQ-022 SHALL, when ZERO_REG0=1, drop writes to address 0, ignore reserve of address 0, and return 0 and busy=0 for address 0 regardless of BYPASS.
REQ-023 SHALL set busy[reserve_addr] on the clock edge when reserve=1.
REQ-024 SHALL clear busy[write_addr] on the clock edge when enable=1 (write retires the producer).
REQ-025 SHALL, when reserve=1 and enable=1 target the same address in one cycle, store write_data and leave busy set (reserve wins).
REQ-026 SHALL, when flush=1, clear all busy bits on the clock edge, overriding reserve in that cycle; register contents unaffected, any write in that cycle still performed.
REQ-027 SHALL drive busy_a/busy_b combinationally from stored busy bits (no bypass of reserve/clear in the same cycle).
REQ-028 SHALL drive any_busy combinationally as OR of all stored busy bits.
REQ-029 SHALL treat both read ports as independent; identical addresses on A and B yield identical data and busy.

Reset
REQ-030 SHALL, while clear=1, asynchronously set every register to INIT (register 0 to 0 when ZERO_REG0=1) and all busy bits to 0.
REQ-031 SHALL ignore enable, reserve and flush while clear=1; operation resumes at the first rising edge after clear deasserts.
REQ-032 SHALL, immediately after reset, present read_data_a/b = INIT (or 0 for register 0 when ZERO_REG0=1), busy_a=busy_b=any_busy=0.
REQ-033 SHALL, when clear asserts mid-operation, abandon a pending write and discard all busy state without waiting for a clock edge.

Verification
REQ-034 Write 0xDEADBEEF to r5, next cycle read_addr_a=5 -> read_data_a=0xDEADBEEF; same-cycle read with BYPASS=1 -> 0xDEADBEEF, with BYPASS=0 -> prior value.
REQ-035 ZERO_REG0=1: write 0x12345678 to r0 and reserve r0 -> read_data_a=0, busy_a=0, any_busy=0.
REQ-036 Reserve r3, then read_addr_b=3 -> busy_b=1, any_busy=1; write r3=0xA5 -> next cycle busy_b=0, read_data_b=0xA5.
REQ-037 Same cycle reserve r7 and write r7=0x55 -> next cycle read_data=0x55, busy=1; flush with reserve r2 same cycle -> all busy=0.
REQ-038 INIT=0xFFFF0000: assert clear between clock edges after writing r9=0x1 -> r9 reads 0xFFFF0000 and any_busy=0 before next edge.
REQ-039 Read ports A and B both at r4 while writing r4=0x77 with BYPASS=1 -> both read 0x77 in that cycle.
